conv_3x3_weight_load_ctrl: RTL and testbench

Sequencing controller for a 3x3 convolution weight buffer. It takes a layer's kernel weights from an upstream valid/ready stream and pushes them into the buffer's shift chain, 9 words per kernel. It waits a fixed settle time after each kernel so the buffer can commit it to its FIFOs, and it tracks FIFO occupancy as credits. When the convolution engine requests a kernel, it issues a one-cycle `load_weights` pulse. It sits between the weight DMA/ROM reader and the 3x3 weight buffer of each conv stage.

---
 rtl/conv_3x3_weight_load_ctrl_pkg.sv | 19 +
 rtl/conv_3x3_weight_credit_cnt.sv | 52 +++++
 rtl/conv_3x3_weight_load_ctrl.sv | 166 ++++++++++++++++
 tb/tb_conv_3x3_weight_load_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_3x3_weight_load_ctrl_pkg.sv
// Shared definitions for the 3x3 convolution weight-load controller:
// FSM state encoding, default kernel size and a counter-width helper.
package conv_3x3_weight_load_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_DRAIN  = 2'd3
    } ctrl_state_e;

    localparam int DEF_KERNEL_SIZE = 9;

    // Bits needed for a counter that must represent 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/conv_3x3_weight_credit_cnt.sv
// Occupancy (credit) counter for the weight buffer FIFOs. Counts kernels
// that are stored but not yet loaded. Saturates at DEPTH and never
// underflows; a simultaneous inc/dec leaves the count unchanged.
module conv_3x3_weight_credit_cnt
    import conv_3x3_weight_load_ctrl_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             full
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ZERO_C  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nx_s;
    logic             full_r;

    // Next occupancy: bounded increment/decrement, hold on both or neither.
    always_comb begin
        count_nx_s = count_r;
        if (inc && !dec && (count_r != DEPTH_C)) begin
            count_nx_s = count_r + ONE_C;
        end else if (dec && !inc && (count_r != ZERO_C)) begin
            count_nx_s = count_r - ONE_C;
        end else begin
            count_nx_s = count_r;
        end
    end

    // Register count and the at-capacity flag together so both are glitch-free.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= ZERO_C;
            full_r  <= 1'b0;
        end else begin
            count_r <= count_nx_s;
            full_r  <= (count_nx_s == DEPTH_C);
        end
    end

    assign count = count_r;
    assign full  = full_r;

endmodule

// File: rtl/conv_3x3_weight_load_ctrl.sv
// Weight-load sequencer for a 3x3 conv weight buffer. Streams KERNEL_SIZE
// words per kernel from upstream into the buffer shift chain, waits
// SETTLE_CYCLES for the buffer to commit each kernel, tracks stored kernels
// as credits, and issues one-cycle load pulses on engine request.
module conv_3x3_weight_load_ctrl
    import conv_3x3_weight_load_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int KERNEL_SIZE   = DEF_KERNEL_SIZE,
    parameter int TOTAL_KERNELS = 2304,
    parameter int FIFO_DEPTH    = 16,
    parameter int SETTLE_CYCLES = 10,
    parameter int CNT_WIDTH     = 12
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic                               w_valid,
    input  logic [DATA_WIDTH-1:0]              w_data,
    output logic                               w_ready,
    input  logic                               kernel_req,
    output logic                               buf_valid_in,
    output logic [DATA_WIDTH-1:0]              buf_in,
    output logic                               buf_load_weights,
    output logic                               kernel_avail,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    occupancy,
    output logic                               busy,
    output logic                               done
);

    localparam int OCC_W    = $clog2(FIFO_DEPTH + 1);
    localparam int WORD_W   = cnt_width(KERNEL_SIZE);
    localparam int SETTLE_W = cnt_width(SETTLE_CYCLES);

    localparam logic [WORD_W-1:0]    LAST_WORD_C   = WORD_W'(KERNEL_SIZE - 1);
    localparam logic [SETTLE_W-1:0]  LAST_SETTLE_C = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] TOTAL_C       = CNT_WIDTH'(TOTAL_KERNELS);
    localparam logic [OCC_W-1:0]     OCC_ZERO_C    = {OCC_W{1'b0}};

    ctrl_state_e             state_r;
    logic [WORD_W-1:0]       word_cnt_r;
    logic [SETTLE_W-1:0]     settle_cnt_r;
    logic [CNT_WIDTH-1:0]    fetched_r;
    logic [CNT_WIDTH-1:0]    loaded_r;
    logic                    busy_r;
    logic                    done_r;
    logic                    buf_valid_in_r;
    logic [DATA_WIDTH-1:0]   buf_in_r;
    logic                    buf_load_weights_r;

    logic                    w_ready_s;
    logic                    transfer_s;
    logic                    last_word_s;
    logic                    settle_done_s;
    logic                    load_fire_s;
    logic                    cap_full_s;
    logic [OCC_W-1:0]        occ_s;

    // Decode handshake and event strobes from registered state only.
    // While fetching no kernel is settling, so pending occupancy equals the
    // stored count and the credit counter's full flag gates w_ready.
    always_comb begin
        w_ready_s     = (state_r == ST_FETCH) && !cap_full_s;
        transfer_s    = w_valid && w_ready_s;
        last_word_s   = (word_cnt_r == LAST_WORD_C);
        settle_done_s = (state_r == ST_SETTLE) && (settle_cnt_r == LAST_SETTLE_C);
        load_fire_s   = (state_r != ST_IDLE) && kernel_req &&
                        (occ_s != OCC_ZERO_C) && !buf_load_weights_r;
    end

    conv_3x3_weight_credit_cnt #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (OCC_W)
    ) u_credit_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (settle_done_s),
        .dec   (load_fire_s),
        .count (occ_s),
        .full  (cap_full_s)
    );

    // Main sequencer: layer FSM, word/settle/kernel counters and all
    // registered buffer-side outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r            <= ST_IDLE;
            word_cnt_r         <= {WORD_W{1'b0}};
            settle_cnt_r       <= {SETTLE_W{1'b0}};
            fetched_r          <= {CNT_WIDTH{1'b0}};
            loaded_r           <= {CNT_WIDTH{1'b0}};
            busy_r             <= 1'b0;
            done_r             <= 1'b0;
            buf_valid_in_r     <= 1'b0;
            buf_in_r           <= {DATA_WIDTH{1'b0}};
            buf_load_weights_r <= 1'b0;
        end else begin
            buf_valid_in_r     <= transfer_s;
            buf_load_weights_r <= load_fire_s;
            done_r             <= 1'b0;
            if (transfer_s) begin
                buf_in_r <= w_data;
            end
            if (load_fire_s) begin
                loaded_r <= loaded_r + CNT_WIDTH'(1);
            end

            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        busy_r       <= 1'b1;
                        fetched_r    <= {CNT_WIDTH{1'b0}};
                        loaded_r     <= {CNT_WIDTH{1'b0}};
                        word_cnt_r   <= {WORD_W{1'b0}};
                        settle_cnt_r <= {SETTLE_W{1'b0}};
                        state_r      <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    // A stall simply leaves word_cnt_r untouched.
                    if (transfer_s) begin
                        if (last_word_s) begin
                            word_cnt_r   <= {WORD_W{1'b0}};
                            fetched_r    <= fetched_r + CNT_WIDTH'(1);
                            settle_cnt_r <= {SETTLE_W{1'b0}};
                            state_r      <= ST_SETTLE;
                        end else begin
                            word_cnt_r <= word_cnt_r + WORD_W'(1);
                        end
                    end
                end
                ST_SETTLE: begin
                    // Expiry edge bumps occupancy (via settle_done_s) and
                    // fetch resumes in the very next cycle.
                    if (settle_done_s) begin
                        settle_cnt_r <= {SETTLE_W{1'b0}};
                        state_r      <= (fetched_r < TOTAL_C) ? ST_FETCH : ST_DRAIN;
                    end else begin
                        settle_cnt_r <= settle_cnt_r + SETTLE_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (loaded_r == TOTAL_C) begin
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign w_ready          = w_ready_s;
    assign buf_valid_in     = buf_valid_in_r;
    assign buf_in           = buf_in_r;
    assign buf_load_weights = buf_load_weights_r;
    assign occupancy        = occ_s;
    assign kernel_avail     = (occ_s != OCC_ZERO_C);
    assign busy             = busy_r;
    assign done             = done_r;

endmodule

// File: tb/tb_conv_3x3_weight_load_ctrl.sv
// Self-checking bench for conv_3x3_weight_load_ctrl: a hand-derived vector
// table for backpressure/simultaneous-event/drain corners, hand sequences for
// underflow guard and mid-layer reset, then randomized layers. Every cycle
// is also compared against a behavioural reference model.
module tb_conv_3x3_weight_load_ctrl;

    localparam int DW    = 32;
    localparam int KS    = 9;
    localparam int TK    = 4;
    localparam int DEPTH = 2;
    localparam int SC    = 10;
    localparam int CW    = 12;
    localparam int OW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          w_valid = 1'b0;
    logic [DW-1:0] w_data = '0;
    logic          kernel_req = 1'b0;
    logic          w_ready;
    logic          buf_valid_in;
    logic [DW-1:0] buf_in;
    logic          buf_load_weights;
    logic          kernel_avail;
    logic [OW-1:0] occupancy;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    conv_3x3_weight_load_ctrl #(
        .DATA_WIDTH    (DW),
        .KERNEL_SIZE   (KS),
        .TOTAL_KERNELS (TK),
        .FIFO_DEPTH    (DEPTH),
        .SETTLE_CYCLES (SC),
        .CNT_WIDTH     (CW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .w_valid          (w_valid),
        .w_data           (w_data),
        .w_ready          (w_ready),
        .kernel_req       (kernel_req),
        .buf_valid_in     (buf_valid_in),
        .buf_in           (buf_in),
        .buf_load_weights (buf_load_weights),
        .kernel_avail     (kernel_avail),
        .occupancy        (occupancy),
        .busy             (busy),
        .done             (done)
    );

    int cmp_cnt  = 0;
    int fail_cnt = 0;

    // Reference model: layer progress as plain integers.
    bit          m_busy, m_bufv, m_load, m_done;
    int          m_words, m_settle, m_fetched, m_loaded, m_occ;
    logic [DW-1:0] m_bufd;

    function automatic bit m_ready();
        return m_busy && (m_settle == 0) && (m_fetched < TK) && (m_occ < DEPTH);
    endfunction

    task automatic model_reset();
        m_busy = 0; m_bufv = 0; m_load = 0; m_done = 0;
        m_words = 0; m_settle = 0; m_fetched = 0; m_loaded = 0; m_occ = 0;
        m_bufd = '0;
    endtask

    task automatic model_edge();
        bit fetching, draining, rdy, xfer, ld, expire;
        int pre_loaded;
        fetching   = m_busy && (m_settle == 0) && (m_fetched < TK);
        draining   = m_busy && (m_settle == 0) && (m_fetched == TK);
        rdy        = fetching && (m_occ < DEPTH);
        xfer       = w_valid && rdy;
        ld         = m_busy && kernel_req && (m_occ > 0) && !m_load;
        expire     = (m_settle == 1);
        pre_loaded = m_loaded;
        m_bufv = xfer;
        if (xfer) m_bufd = w_data;
        m_load = ld;
        m_done = 0;
        m_occ  = m_occ + (expire ? 1 : 0) - (ld ? 1 : 0);
        if (ld) m_loaded++;
        if (!m_busy) begin
            if (start) begin
                m_busy = 1; m_fetched = 0; m_loaded = 0; m_words = 0;
            end
        end else if (xfer) begin
            m_words++;
            if (m_words == KS) begin
                m_words = 0; m_fetched++; m_settle = SC;
            end
        end else if (m_settle > 0) begin
            m_settle--;
        end else if (draining && pre_loaded == TK) begin
            m_busy = 0; m_done = 1;
        end
    endtask

    function automatic logic [63:0] act_vec();
        return 64'({w_ready, buf_valid_in, buf_in, buf_load_weights,
                    occupancy, kernel_avail, busy, done});
    endfunction

    function automatic logic [63:0] exp_vec();
        logic [OW-1:0] occ_v;
        occ_v = OW'(m_occ);
        return 64'({m_ready(), m_bufv, m_bufd, m_load, occ_v, (m_occ > 0), m_busy, m_done});
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: advance model on the edge, compare on the falling edge.
    task automatic step();
        @(posedge clk);
        if (reset) model_edge(); else model_reset();
        @(negedge clk);
        chk("model", act_vec(), exp_vec());
    endtask

    typedef struct {
        bit st; bit wv; bit kr; int n;
        bit e_rdy; bit e_bv; logic [DW-1:0] e_bin; bit e_ld; int e_occ; bit e_busy; bit e_done;
    } vec_t;

    function automatic vec_t mk(bit st, bit wv, bit kr, int n, bit rdy, bit bv,
                                int bin, bit ld, int occ, bit bz, bit dn);
        vec_t v;
        v.st = st; v.wv = wv; v.kr = kr; v.n = n;
        v.e_rdy = rdy; v.e_bv = bv; v.e_bin = DW'(bin); v.e_ld = ld;
        v.e_occ = occ; v.e_busy = bz; v.e_done = dn;
        return v;
    endfunction

    vec_t tbl[18];
    int   word_seq;

    initial begin
        logic [OW-1:0] eo;
        int loads_seen;
        bit got_done;

        // start wv kr  n   rdy bv bin ld occ busy done
        tbl[0]  = mk(1, 0, 0, 1,  1, 0, 0,  0, 0, 1, 0); // start layer
        tbl[1]  = mk(0, 1, 0, 9,  0, 1, 9,  0, 0, 1, 0); // kernel 1 words 1..9
        tbl[2]  = mk(0, 1, 0, 10, 1, 0, 9,  0, 1, 1, 0); // settle expires
        tbl[3]  = mk(0, 1, 0, 9,  0, 1, 18, 0, 1, 1, 0); // kernel 2
        tbl[4]  = mk(0, 1, 0, 10, 0, 0, 18, 0, 2, 1, 0); // full: ready drops
        tbl[5]  = mk(1, 1, 0, 5,  0, 0, 18, 0, 2, 1, 0); // held off, start ignored
        tbl[6]  = mk(0, 1, 1, 1,  1, 0, 18, 1, 1, 1, 0); // load frees a credit
        tbl[7]  = mk(0, 1, 0, 1,  1, 1, 19, 0, 1, 1, 0); // fetch resumes
        tbl[8]  = mk(0, 1, 0, 8,  0, 1, 27, 0, 1, 1, 0); // kernel 3 done
        tbl[9]  = mk(1, 1, 0, 9,  0, 0, 27, 0, 1, 1, 0); // settling, start ignored
        tbl[10] = mk(0, 1, 1, 1,  1, 0, 27, 1, 1, 1, 0); // expiry + load same edge
        tbl[11] = mk(0, 1, 0, 9,  0, 1, 36, 0, 1, 1, 0); // kernel 4
        tbl[12] = mk(0, 1, 0, 10, 0, 0, 36, 0, 2, 1, 0); // into drain
        tbl[13] = mk(0, 0, 1, 1,  0, 0, 36, 1, 1, 1, 0); // load
        tbl[14] = mk(0, 0, 1, 1,  0, 0, 36, 0, 1, 1, 0); // back-to-back blocked
        tbl[15] = mk(0, 0, 1, 1,  0, 0, 36, 1, 0, 1, 0); // last load
        tbl[16] = mk(0, 0, 1, 1,  0, 0, 36, 0, 0, 0, 1); // done, busy falls
        tbl[17] = mk(0, 0, 0, 1,  0, 0, 36, 0, 0, 0, 0); // done is one cycle

        model_reset();
        @(negedge clk);
        chk("reset_state", act_vec(), 64'd0);
        step();
        reset = 1'b1;

        // Table-driven layer with FIFO_DEPTH=2 backpressure.
        word_seq = 1;
        w_data   = DW'(word_seq);
        for (int i = 0; i < 18; i++) begin
            start = tbl[i].st; w_valid = tbl[i].wv; kernel_req = tbl[i].kr;
            for (int c = 0; c < tbl[i].n; c++) begin
                step();
                if (m_bufv) word_seq++;
                w_data = DW'(word_seq);
                start  = 1'b0;
                if (i == 5 || i == 9) start = 1'b1;
            end
            eo = OW'(tbl[i].e_occ);
            chk($sformatf("tbl_row%0d", i), act_vec(),
                64'({tbl[i].e_rdy, tbl[i].e_bv, tbl[i].e_bin, tbl[i].e_ld,
                     eo, (tbl[i].e_occ > 0), tbl[i].e_busy, tbl[i].e_done}));
        end

        // Underflow guard: request held high from the start of a new layer.
        start = 1'b1; w_valid = 1'b0; kernel_req = 1'b1;
        step();
        start = 1'b0; w_valid = 1'b1;
        loads_seen = 0;
        repeat (19) begin
            step();
            if (buf_load_weights) loads_seen++;
            w_data = w_data + DW'(1);
        end
        chk("underflow_no_load", 64'(loads_seen), 64'd0);
        chk("first_settle_occ", 64'(occupancy), 64'd1);
        step();
        w_data = w_data + DW'(1);
        chk("held_req_load", 64'({buf_load_weights, occupancy}), 64'({1'b1, OW'(0)}));
        repeat (3) begin
            step();
            w_data = w_data + DW'(1);
        end

        // Reset mid-kernel (word 5 presented): outputs clear immediately.
        reset = 1'b0;
        #1;
        model_reset();
        chk("reset_mid_layer", act_vec(), 64'd0);
        repeat (2) step();
        reset = 1'b1;

        // Randomized layers: random valid, stall-every-other, sparse requests.
        for (int l = 0; l < 3; l++) begin
            start = 1'b1; w_valid = 1'b0; kernel_req = 1'b0;
            step();
            got_done = 1'b0;
            for (int c = 0; c < 3000 && !got_done; c++) begin
                w_valid    = (l == 1) ? c[0] : ($urandom_range(3) != 0);
                kernel_req = (l == 2) ? ($urandom_range(7) == 0) : 1'($urandom_range(1));
                start      = ($urandom_range(15) == 0);
                w_data     = $urandom;
                step();
                if (done) got_done = 1'b1;
            end
            chk($sformatf("layer%0d_done", l), 64'(got_done), 64'd1);
            start = 1'b0; w_valid = 1'b0; kernel_req = 1'b0;
            repeat (2) step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule
